// File: rtl/period_pulse_gen.sv
// period_pulse_gen: programmable periodic pulse generator.
// Rising edges of pulse_out are exactly one active period apart; the high time
// is programmable. New period/high values wait in a shadow until the next
// period boundary. A rising edge on sync_in restarts the period.
// Optional feature macro PULSE_TRIM_EN: one-shot signed adjust of one period.
module period_pulse_gen #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned DEFAULT_PERIOD = 10000000,
  parameter int unsigned DEFAULT_HIGH   = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] high_in,
  input  logic             load,
  input  logic             sync_in,
  input  logic [15:0]      trim_in,
  input  logic             trim_valid,
  output logic             pulse_out,
  output logic             boundary,
  output logic             pending,
  output logic [WIDTH-1:0] period_count
);

  // state | meaning
  // IDLE  | output low, counter held at 0, waiting for enable
  // RUN   | counting through the active period, pulse high for high time
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [WIDTH-1:0] RST_PER  = WIDTH'(DEFAULT_PERIOD);
  localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(DEFAULT_HIGH);

  function automatic logic [WIDTH-1:0] clamp_per(input logic [WIDTH-1:0] p);
    return (p < WIDTH'(2)) ? WIDTH'(2) : p;
  endfunction

  function automatic logic [WIDTH-1:0] clamp_high(input logic [WIDTH-1:0] h,
                                                  input logic [WIDTH-1:0] p);
    return (h >= p) ? (p - WIDTH'(1)) : h;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             bnd_q, bnd_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] per_act_q, per_act_d, high_act_q, high_act_d;
  logic [WIDTH-1:0] sh_per_q, sh_per_d, sh_high_q, sh_high_d;
  logic             pend_q, pend_d;
  logic [2:0]       sync_q;

  logic             sync_pulse, starting, wrap, new_period;
  logic [WIDTH-1:0] ld_per, ld_high, nxt_per, nxt_high;
  logic [WIDTH-1:0] new_len, new_high, cur_per, cur_high;

  // sync_q[1:0] synchronize sync_in, sync_q[2] delays once more for edge detect
  assign sync_pulse = sync_q[1] & ~sync_q[2];

  assign ld_per  = clamp_per(period_in);
  assign ld_high = clamp_high(high_in, ld_per);

  // Parameters for a period that starts this cycle: a coincident load
  // bypasses the shadow, otherwise a pending shadow is applied.
  assign nxt_per  = load ? ld_per  : (pend_q ? sh_per_q  : per_act_q);
  assign nxt_high = load ? ld_high : (pend_q ? sh_high_q : high_act_q);

  assign starting   = (state_q == S_IDLE) && enable;
  assign wrap       = (state_q == S_RUN) && enable &&
                      ((cnt_q == cur_per - WIDTH'(1)) || sync_pulse);
  assign new_period = starting || wrap;

`ifdef PULSE_TRIM_EN
  logic [15:0]             trim_q, trim_d;
  logic                    trim_pend_q, trim_pend_d;
  logic [WIDTH-1:0]        len_q, len_d, lhigh_q, lhigh_d;
  logic signed [WIDTH+1:0] trim_sum;
  logic [WIDTH-1:0]        trim_len;

  assign trim_sum = $signed({2'b00, nxt_per}) +
                    $signed({{(WIDTH-14){trim_q[15]}}, trim_q});

  // Saturate the trimmed length into [2, 2^WIDTH-1]
  always_comb begin
    trim_len = trim_sum[WIDTH-1:0];
    if (trim_sum[WIDTH+1] || (!trim_sum[WIDTH] && (trim_sum[WIDTH-1:0] < WIDTH'(2))))
      trim_len = WIDTH'(2);
    else if (trim_sum[WIDTH])
      trim_len = '1;
  end

  assign new_len  = trim_pend_q ? trim_len : nxt_per;
  assign cur_per  = len_q;
  assign cur_high = lhigh_q;

  // Trim is consumed by the first period that starts after it was captured
  always_comb begin
    trim_d      = trim_q;
    trim_pend_d = trim_pend_q;
    len_d       = len_q;
    lhigh_d     = lhigh_q;
    if (new_period) begin
      len_d       = new_len;
      lhigh_d     = new_high;
      trim_pend_d = 1'b0;
    end
    if (trim_valid) begin
      trim_d      = trim_in;
      trim_pend_d = 1'b1;
    end
  end

  // Trim and effective-length registers
  always_ff @(posedge clk) begin
    if (rst) begin
      trim_q      <= '0;
      trim_pend_q <= 1'b0;
      len_q       <= RST_PER;
      lhigh_q     <= RST_HIGH;
    end else begin
      trim_q      <= trim_d;
      trim_pend_q <= trim_pend_d;
      len_q       <= len_d;
      lhigh_q     <= lhigh_d;
    end
  end
`else
  logic unused_trim;
  assign unused_trim = ^{trim_in, trim_valid};
  assign new_len     = nxt_per;
  assign cur_per     = per_act_q;
  assign cur_high    = high_act_q;
`endif

  assign new_high = clamp_high(nxt_high, new_len);

  // Next-state for the period FSM, counter, outputs and shadow registers
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pulse_d    = pulse_q;
    bnd_d      = 1'b0;
    pc_d       = pc_q;
    per_act_d  = per_act_q;
    high_act_d = high_act_q;
    sh_per_d   = sh_per_q;
    sh_high_d  = sh_high_q;
    pend_d     = pend_q;
    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (enable) begin
          state_d = S_RUN;
          bnd_d   = 1'b1;
          pulse_d = (new_high != '0);
        end
      end
      default: begin
        if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          pulse_d = 1'b0;
        end else if (wrap) begin
          cnt_d   = '0;
          bnd_d   = 1'b1;
          pc_d    = pc_q + WIDTH'(1);
          pulse_d = (new_high != '0);
        end else begin
          cnt_d   = cnt_q + WIDTH'(1);
          pulse_d = ((cnt_q + WIDTH'(1)) < cur_high);
        end
      end
    endcase
    if (new_period) begin
      per_act_d  = nxt_per;
      high_act_d = nxt_high;
      pend_d     = 1'b0;
    end else if (load) begin
      sh_per_d  = ld_per;
      sh_high_d = ld_high;
      pend_d    = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
      bnd_q      <= 1'b0;
      pc_q       <= '0;
      per_act_q  <= RST_PER;
      high_act_q <= RST_HIGH;
      sh_per_q   <= RST_PER;
      sh_high_q  <= RST_HIGH;
      pend_q     <= 1'b0;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
      bnd_q      <= bnd_d;
      pc_q       <= pc_d;
      per_act_q  <= per_act_d;
      high_act_q <= high_act_d;
      sh_per_q   <= sh_per_d;
      sh_high_q  <= sh_high_d;
      pend_q     <= pend_d;
      sync_q     <= {sync_q[1:0], sync_in};
    end
  end

  assign pulse_out    = pulse_q;
  assign boundary     = bnd_q;
  assign pending      = pend_q;
  assign period_count = pc_q;

endmodule

// File: tb/tb_period_pulse_gen.sv
// Bench for period_pulse_gen: directed literal checks plus randomized traffic
// compared every cycle against a position-within-period model.
module tb_period_pulse_gen;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, enable, load, sync_in, trim_valid;
  logic [W-1:0] period_in, high_in;
  logic [15:0]  trim_in;
  logic         pulse_out, boundary, pending;
  logic [W-1:0] period_count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  period_pulse_gen #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period_in(period_in),
    .high_in(high_in), .load(load), .sync_in(sync_in), .trim_in(trim_in),
    .trim_valid(trim_valid), .pulse_out(pulse_out), .boundary(boundary),
    .pending(pending), .period_count(period_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // Model: outputs follow from the position inside the current period
  bit     m_run, m_pend, m_tp;
  longint m_pos, m_len, m_high, m_per, m_hi, m_sh_per, m_sh_hi, m_pc, m_trim;
  bit     hist[1:3];
  bit     evt, newp;
  longint lp, lh;

  always @(posedge clk) begin
    evt = hist[2] & ~hist[3];
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = sync_in;
    if (rst) begin
      m_run = 0; m_pend = 0; m_tp = 0; m_trim = 0; m_pos = 0; m_pc = 0;
      m_per = 10000000; m_hi = 1000000; m_sh_per = m_per; m_sh_hi = m_hi;
      m_len = m_per; m_high = m_hi;
      hist[1] = 0; hist[2] = 0; hist[3] = 0;
    end else begin
      newp = 0;
      if (!m_run) begin
        if (enable) begin m_run = 1; newp = 1; end
      end else if (!enable) begin
        m_run = 0;
      end else if (m_pos == m_len - 1 || evt) begin
        newp = 1;
        m_pc = (m_pc + 1) % 64'h1_0000_0000;
      end else begin
        m_pos++;
      end
      lp = (period_in < 2) ? 2 : longint'(period_in);
      lh = (high_in >= lp) ? lp - 1 : longint'(high_in);
      if (newp) begin
        if (load) begin m_per = lp; m_hi = lh; end
        else if (m_pend) begin m_per = m_sh_per; m_hi = m_sh_hi; end
        m_pend = 0;
        m_len = m_per;
`ifdef PULSE_TRIM_EN
        if (m_tp) m_len = m_per + m_trim;
        if (m_len < 2) m_len = 2;
        m_tp = 0;
`endif
        m_high = (m_hi >= m_len) ? m_len - 1 : m_hi;
        m_pos = 0;
      end else if (load) begin
        m_sh_per = lp; m_sh_hi = lh; m_pend = 1;
      end
`ifdef PULSE_TRIM_EN
      if (trim_valid) begin m_trim = longint'($signed(trim_in)); m_tp = 1; end
`endif
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_pulse", pulse_out, (m_run && m_pos < m_high) ? 1 : 0);
      check("m_boundary", boundary, (m_run && m_pos == 0) ? 1 : 0);
      check("m_pending", pending, m_pend);
      check("m_count", longint'(period_count), m_pc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bnd(output int n);
    n = 0;
    do begin tick(); n++; end while (!boundary && n < 40);
    check("bnd_wait", boundary, 1);
  endtask

  initial begin
    int n;
    longint pc0;
    rst = 1; enable = 0; load = 0; sync_in = 0; trim_valid = 0;
    period_in = '0; high_in = '0; trim_in = '0;
    tick(); tick(); tick();
    chk_en = 1;
    check("rst_pulse", pulse_out, 0);
    check("rst_bnd", boundary, 0);
    check("rst_pend", pending, 0);
    check("rst_count", longint'(period_count), 0);
    rst = 0;

    // Basic 10/3 train
    period_in = 10; high_in = 3; load = 1;
    tick();
    load = 0;
    check("load_pend", pending, 1);
    enable = 1;
    tick();
    for (int i = 0; i < 50; i++) begin
      check("basic_pulse", pulse_out, (i % 10 < 3) ? 1 : 0);
      check("basic_bnd", boundary, (i % 10 == 0) ? 1 : 0);
      tick();
    end
    check("basic_count5", longint'(period_count), 5);

    // Mid-run reprogram to 6/2
    tick(); tick(); tick(); tick();
    period_in = 6; high_in = 2; load = 1;
    tick();
    load = 0;
    check("mid_pend", pending, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("mid_pend_hold", pending, 1);
      check("mid_old_low", pulse_out, 0);
    end
    tick();
    check("mid_wrap_bnd", boundary, 1);
    check("mid_wrap_pend", pending, 0);
    check("mid_wrap_pulse", pulse_out, 1);
    for (int i = 1; i < 12; i++) begin
      tick();
      check("p6_pulse", pulse_out, (i % 6 < 2) ? 1 : 0);
      check("p6_bnd", boundary, (i % 6 == 0) ? 1 : 0);
    end

    // Clamp: period 1, high 5 -> 2/1
    period_in = 1; high_in = 5; load = 1;
    tick();
    load = 0;
    wait_bnd(n);
    for (int i = 1; i < 7; i++) begin
      tick();
      check("clamp_alt", pulse_out, (i % 2 == 0) ? 1 : 0);
    end

    // Sync realign on a 10/3 train
    period_in = 10; high_in = 3; load = 1;
    tick();
    load = 0;
    wait_bnd(n);
    wait_bnd(n);
    check("p10_len", n, 10);
    tick(); tick();
    pc0 = m_pc;
    sync_in = 1;
    tick();
    check("sync_e0_pulse", pulse_out, 0);
    tick();
    check("sync_e1_pulse", pulse_out, 0);
    check("sync_e1_bnd", boundary, 0);
    tick();
    check("sync_e2_bnd", boundary, 1);
    check("sync_e2_pulse", pulse_out, 1);
    check("sync_count", longint'(period_count), pc0 + 1);
    for (int i = 1; i < 10; i++) begin
      tick();
      check("sync_after_bnd", boundary, 0);
    end
    tick();
    check("sync_next_bnd", boundary, 1);
    check("sync_count2", longint'(period_count), pc0 + 2);
    sync_in = 0;

    // One-shot trim of -3
    wait_bnd(n);
    trim_in = 16'hFFFD; trim_valid = 1;
    tick();
    trim_valid = 0; trim_in = '0;
    wait_bnd(n);
    wait_bnd(n);
`ifdef PULSE_TRIM_EN
    check("trim_len", n, 7);
`else
    check("trim_len", n, 10);
`endif
    wait_bnd(n);
    check("trim_after_len", n, 10);

    // Disable stops immediately
    enable = 0;
    tick();
    check("dis_pulse", pulse_out, 0);
    check("dis_bnd", boundary, 0);

    // Randomized traffic checked by the model
    for (int c = 0; c < 4000; c++) begin
      rst        = ($urandom_range(0, 999) == 0);
      enable     = ($urandom_range(0, 99) < 93);
      load       = ($urandom_range(0, 99) < 6);
      period_in  = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF : W'($urandom_range(0, 15));
      high_in    = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF : W'($urandom_range(0, 17));
      if ($urandom_range(0, 99) < 4) sync_in = ~sync_in;
      trim_valid = ($urandom_range(0, 99) < 3);
      trim_in    = 16'(int'($urandom_range(0, 16)) - 8);
      tick();
    end
    rst = 0; load = 0; trim_valid = 0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/period_pulse_gen.md
Name: period_pulse_gen

Overview:
Programmable periodic pulse generator, the transmit-side counterpart of the coarse period counter. Drives a pulse train whose rising edges are exactly PERIOD clk cycles apart, with a programmable high time. Used to generate PPS/reference outputs and to self-test the counter path. Supports glitch-free reprogramming at period boundaries and phase realignment to an external edge.

Parameters:
WIDTH, 32, width of period/high/count registers
DEFAULT_PERIOD, 10000000, period in clk cycles after reset
DEFAULT_HIGH, 1000000, high time in clk cycles after reset

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable  in  1  level; 1 = generate, 0 = stop (output low)
period_in  in  WIDTH  new period in clk cycles
high_in  in  WIDTH  new high time in clk cycles
load  in  1  1-cycle strobe; capture period_in/high_in into shadow
sync_in  in  1  asynchronous realign input, rising edge active
trim_in  in  16  signed one-shot period adjust (feature-gated)
trim_valid  in  1  1-cycle strobe for trim_in (feature-gated)
pulse_out  out  1  generated pulse train (registered)
boundary  out  1  1-cycle strobe, first cycle of each period
pending  out  1  shadow loaded, not yet applied
period_count  out  WIDTH  completed-period counter

Behaviour:
- Reset: state IDLE; cnt=0; pulse_out=0; boundary=0; pending=0; period_count=0; active and shadow regs = DEFAULT_PERIOD/DEFAULT_HIGH.
- Clamping on capture: period <2 -> 2; high >= period -> period-1. high=0 legal: output stays low, boundary still fires.
- States: IDLE, RUN.
- IDLE: pulse_out=0, boundary=0, cnt held 0. At clock with enable=1 (pending applied first): -> RUN, cnt<=0, boundary<=1, pulse_out<=(high_act!=0).
- RUN, each clock: if enable=0 -> IDLE, pulse_out<=0, boundary<=0, cnt<=0 (immediate stop, partial period allowed). Else if cnt==period_act-1 (wrap): cnt<=0, boundary<=1, period_count<=period_count+1 (wraps at 2^WIDTH), apply shadow if pending (pending<=0), pulse_out<=(new high!=0). Else cnt<=cnt+1, boundary<=0, pulse_out<=(cnt+1 < high_act).
- Result: pulse_out high for exactly high_act cycles of every period_act-cycle period; rising edges period_act cycles apart.
- load: shadow<=clamped inputs, pending<=1. Repeated loads before a wrap: last wins. load coincident with wrap: new values bypass shadow and govern the period starting at that wrap; pending stays 0.
- sync_in: 2-flop synchronizer plus third flop for edge detect; sync_pulse = s1 & ~s2. In RUN, sync_pulse forces a wrap (restart, boundary, period_count++, pending applied). pulse_out rises on the 3rd clk edge after the first edge sampling sync_in=1. Ignored in IDLE. Coincident with natural wrap: single wrap, single increment.
- Reset mid-period: all regs return to reset values next edge; pending shadow discarded.

Optional Feature:
PULSE_TRIM_EN: when defined, trim_valid captures signed trim_in; the next full period uses period_act+trim (clamped >=2, and high clamped to that length-1), then trim clears. Second trim before use overwrites. Trim applies to the period after the wrap in which it was captured if coincident. When undefined, trim_in/trim_valid ports exist but are ignored; all periods equal period_act.

Test Plan:
- Reset, period_in=10, high_in=3, load, enable=1 -> pulse_out pattern 1,1,1,0x7 repeating; boundary every 10 cycles; period_count=5 after 50 cycles.
- Mid-run load period=6, high=2 -> current 10-cycle period completes unchanged; pending=1 until wrap; next periods 6 cycles, 2 high.
- period_in=1, high_in=5, load -> clamped to period 2, high 1: alternating 1,0.
- sync_in rises at cnt=4 of 10-cycle period -> pulse_out rises at 3rd clk edge after sampling, cnt restarts at 0, period_count +1 only once.
- Loop pulse_out into coarse period counter (rising mode), period 1000 -> counter reads 1000 steady.
- PULSE_TRIM_EN defined, trim_in=-3 on period 10 -> one period of 7, then 10; undefined -> all periods 10.
